// File: rtl/lkp_pkg.sv
// Shared definitions for the lookup table responder: sizing helper, miss code
// and the bit layout of a lookup pipeline stage record.
package lkp_pkg;

    function automatic int clogb(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Miss code; users slice the low result_length bits.
    localparam logic [63:0] MISS_RSLT = '1;

    // Stage record layout {vld, req_id, tag, hit, rslt}, rslt in the LSBs.
    function automatic int stg_rslt_lsb();
        return 0;
    endfunction

    function automatic int stg_hit_bit(input int rslt_w);
        return rslt_w;
    endfunction

    function automatic int stg_tag_lsb(input int rslt_w);
        return rslt_w + 1;
    endfunction

    function automatic int stg_req_lsb(input int tag_w, input int rslt_w);
        return rslt_w + 1 + tag_w;
    endfunction

    function automatic int stg_vld_bit(input int req_w, input int tag_w, input int rslt_w);
        return rslt_w + 1 + tag_w + req_w;
    endfunction

    function automatic int stg_width(input int req_w, input int tag_w, input int rslt_w);
        return rslt_w + 1 + tag_w + req_w + 1;
    endfunction

endpackage

// File: rtl/lkp_req_fifo.sv
// Request FIFO for the lookup responder: circular buffer with occupancy count
// and a registered not-full flag used directly as the upstream ready.
module lkp_req_fifo
    import lkp_pkg::*;
#(
    parameter int width = 30,
    parameter int depth = 4,
    localparam int PTR_W = (depth > 1) ? clogb(depth) : 1,
    localparam int CNT_W = clogb(depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             not_full
);

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push && not_full;
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Ready is registered from the post-edge occupancy, so it drops the
    // cycle after the FIFO fills and rises the cycle after reset release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            not_full <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count    <= count_next;
            not_full <= (count_next < CNT_W'(depth));
        end
    end

endmodule

// File: rtl/lkp_table_responder.sv
// Cache lookup responder: queues c2a requests, does a direct-indexed tagged
// table lookup and returns in-order responses. Optional macro: LKP_STATS_EN.
module lkp_table_responder
    import lkp_pkg::*;
#(
    parameter int info_length   = 20,
    parameter int result_length = 20,
    parameter int req_width     = 10,
    parameter int table_depth   = 256,
    parameter int req_depth     = 4,
    parameter int lkp_lat       = 2,
    localparam int idx_w = clogb(table_depth),
    localparam int tag_w = info_length - idx_w
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c2a_lkp_vld,
    input  logic [info_length-1:0]   c2a_lkp_info,
    input  logic [req_width-1:0]     c2a_lkp_req_id,
    output logic                     a2c_lkp_rdy,
    output logic                     a2c_lkp_rsp_vld,
    output logic [req_width-1:0]     a2c_lkp_rsp_id,
    output logic [result_length-1:0] a2c_lkp_rslt,
    input  logic                     cfg_wr_en,
    input  logic [idx_w-1:0]         cfg_wr_idx,
    input  logic                     cfg_wr_vld,
    input  logic [tag_w-1:0]         cfg_wr_tag,
    input  logic [result_length-1:0] cfg_wr_rslt
`ifdef LKP_STATS_EN
    ,
    output logic [31:0]              stat_hit_cnt,
    output logic [31:0]              stat_miss_cnt
`endif
);

    localparam int FIFO_W   = info_length + req_width;
    localparam int CNT_W    = clogb(req_depth + 1);
    localparam int STG_W    = stg_width(req_width, tag_w, result_length);
    localparam int RSLT_LSB = stg_rslt_lsb();
    localparam int HIT_BIT  = stg_hit_bit(result_length);
    localparam int TAG_LSB  = stg_tag_lsb(result_length);
    localparam int REQ_LSB  = stg_req_lsb(tag_w, result_length);
    localparam int VLD_BIT  = stg_vld_bit(req_width, tag_w, result_length);
    localparam int LAST     = lkp_lat - 1;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_not_full;
    logic [FIFO_W-1:0]        fifo_dout;
    logic [CNT_W-1:0]         fifo_count;

    logic [table_depth-1:0]   tbl_vld;
    logic [tag_w-1:0]         tbl_tag  [table_depth];
    logic [result_length-1:0] tbl_rslt [table_depth];

    logic [info_length-1:0]   iss_info;
    logic [req_width-1:0]     iss_id;
    logic [idx_w-1:0]         iss_idx;
    logic [tag_w-1:0]         iss_tag;
    logic                     iss_hit;
    logic [result_length-1:0] iss_rslt;
    logic [STG_W-1:0]         issue_rec;

    logic [STG_W-1:0]         stg_in [lkp_lat];
    logic [STG_W-1:0]         stg    [lkp_lat];
    logic                     unused_stg;

    assign fifo_push   = c2a_lkp_vld && fifo_not_full;
    assign fifo_pop    = (fifo_count != '0) && !cfg_wr_en;
    assign a2c_lkp_rdy = fifo_not_full;

    lkp_req_fifo #(
        .width (FIFO_W),
        .depth (req_depth)
    ) u_req_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      ({c2a_lkp_info, c2a_lkp_req_id}),
        .dout     (fifo_dout),
        .count    (fifo_count),
        .not_full (fifo_not_full)
    );

    // Only the valid bits are reset; tag and result contents are don't-care
    // until an entry is written valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tbl_vld <= '0;
        end else if (cfg_wr_en) begin
            tbl_vld[cfg_wr_idx] <= cfg_wr_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_wr_en) begin
            tbl_tag[cfg_wr_idx]  <= cfg_wr_tag;
            tbl_rslt[cfg_wr_idx] <= cfg_wr_rslt;
        end
    end

    assign iss_info  = fifo_dout[FIFO_W-1 -: info_length];
    assign iss_id    = fifo_dout[req_width-1:0];
    assign iss_idx   = iss_info[idx_w-1:0];
    assign iss_tag   = iss_info[info_length-1:idx_w];
    assign iss_hit   = tbl_vld[iss_idx] && (tbl_tag[iss_idx] == iss_tag);
    assign iss_rslt  = iss_hit ? tbl_rslt[iss_idx] : MISS_RSLT[result_length-1:0];
    assign issue_rec = {fifo_pop, iss_id, iss_tag, iss_hit, iss_rslt};

    always_comb begin
        stg_in[0] = issue_rec;
        for (int i = 1; i < lkp_lat; i++) begin
            stg_in[i] = stg[i-1];
        end
    end

    // The final stage is the response register: its payload only advances
    // with a valid record so rsp_id/rslt hold between responses.
    always_ff @(posedge clk) begin
        for (int i = 0; i < lkp_lat; i++) begin
            if (!rst) begin
                stg[i] <= '0;
            end else if ((i == LAST) && !stg_in[i][VLD_BIT]) begin
                stg[i][VLD_BIT] <= 1'b0;
            end else begin
                stg[i] <= stg_in[i];
            end
        end
    end

    assign a2c_lkp_rsp_vld = stg[LAST][VLD_BIT];
    assign a2c_lkp_rsp_id  = stg[LAST][REQ_LSB +: req_width];
    assign a2c_lkp_rslt    = stg[LAST][RSLT_LSB +: result_length];
    assign unused_stg      = ^{stg[LAST][TAG_LSB +: tag_w], stg[LAST][HIT_BIT]};

`ifdef LKP_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_hit_cnt  <= '0;
            stat_miss_cnt <= '0;
        end else if (stg[LAST][VLD_BIT]) begin
            if (stg[LAST][HIT_BIT]) begin
                if (stat_hit_cnt != '1) begin
                    stat_hit_cnt <= stat_hit_cnt + 32'd1;
                end
            end else if (stat_miss_cnt != '1) begin
                stat_miss_cnt <= stat_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lkp_table_responder.sv
// Directed self-checking bench for lkp_table_responder with hand-computed
// expectations; stats checks compile in when LKP_STATS_EN is defined.
module tb_lkp_table_responder;

    logic        clk;
    logic        rst;
    logic        c2a_lkp_vld;
    logic [19:0] c2a_lkp_info;
    logic [9:0]  c2a_lkp_req_id;
    logic        a2c_lkp_rdy;
    logic        a2c_lkp_rsp_vld;
    logic [9:0]  a2c_lkp_rsp_id;
    logic [19:0] a2c_lkp_rslt;
    logic        cfg_wr_en;
    logic [7:0]  cfg_wr_idx;
    logic        cfg_wr_vld;
    logic [11:0] cfg_wr_tag;
    logic [19:0] cfg_wr_rslt;
`ifdef LKP_STATS_EN
    logic [31:0] stat_hit_cnt;
    logic [31:0] stat_miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    lkp_table_responder dut (
        .clk             (clk),
        .rst             (rst),
        .c2a_lkp_vld     (c2a_lkp_vld),
        .c2a_lkp_info    (c2a_lkp_info),
        .c2a_lkp_req_id  (c2a_lkp_req_id),
        .a2c_lkp_rdy     (a2c_lkp_rdy),
        .a2c_lkp_rsp_vld (a2c_lkp_rsp_vld),
        .a2c_lkp_rsp_id  (a2c_lkp_rsp_id),
        .a2c_lkp_rslt    (a2c_lkp_rslt),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_wr_idx      (cfg_wr_idx),
        .cfg_wr_vld      (cfg_wr_vld),
        .cfg_wr_tag      (cfg_wr_tag),
        .cfg_wr_rslt     (cfg_wr_rslt)
`ifdef LKP_STATS_EN
        ,
        .stat_hit_cnt    (stat_hit_cnt),
        .stat_miss_cnt   (stat_miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    task automatic cfg_write(input logic [7:0] idx, input logic vld, input logic [11:0] tag, input logic [19:0] rslt);
        cfg_wr_en   = 1'b1;
        cfg_wr_idx  = idx;
        cfg_wr_vld  = vld;
        cfg_wr_tag  = tag;
        cfg_wr_rslt = rslt;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    // One request into an idle responder; response expected exactly 3 cycles after acceptance.
    task automatic send_and_check(input string name, input logic [19:0] info, input logic [9:0] id, input logic [19:0] exp_rslt);
        check_output({name, "_rdy"}, 32'(a2c_lkp_rdy), 32'd1);
        c2a_lkp_vld    = 1'b1;
        c2a_lkp_info   = info;
        c2a_lkp_req_id = id;
        tick();
        c2a_lkp_vld = 1'b0;
        check_output({name, "_vld_t1"}, 32'(a2c_lkp_rsp_vld), 32'd0);
        tick();
        check_output({name, "_vld_t2"}, 32'(a2c_lkp_rsp_vld), 32'd0);
        tick();
        check_output({name, "_vld_t3"}, 32'(a2c_lkp_rsp_vld), 32'd1);
        check_output({name, "_id"}, 32'(a2c_lkp_rsp_id), 32'(id));
        check_output({name, "_rslt"}, 32'(a2c_lkp_rslt), 32'(exp_rslt));
        tick();
    endtask

    initial begin : apply_stimulus
        int seen;
        int next_id;
        int pend;

        rst            = 1'b0;
        c2a_lkp_vld    = 1'b0;
        c2a_lkp_info   = '0;
        c2a_lkp_req_id = '0;
        cfg_wr_en      = 1'b0;
        cfg_wr_idx     = '0;
        cfg_wr_vld     = 1'b0;
        cfg_wr_tag     = '0;
        cfg_wr_rslt    = '0;

        $display("[TB] reset state");
        tick();
        tick();
        check_output("rst_rdy", 32'(a2c_lkp_rdy), 32'd0);
        check_output("rst_rsp_vld", 32'(a2c_lkp_rsp_vld), 32'd0);
        check_output("rst_rsp_id", 32'(a2c_lkp_rsp_id), 32'd0);
        check_output("rst_rslt", 32'(a2c_lkp_rslt), 32'd0);
`ifdef LKP_STATS_EN
        check_output("rst_hit_cnt", stat_hit_cnt, 32'd0);
        check_output("rst_miss_cnt", stat_miss_cnt, 32'd0);
`endif
        rst = 1'b1;
        tick();
        check_output("rel_rdy", 32'(a2c_lkp_rdy), 32'd1);

        $display("[TB] hit and miss");
        cfg_write(8'h05, 1'b1, 12'h123, 20'h0ABCD);
        send_and_check("hit", 20'h12305, 10'h2A1, 20'h0ABCD);
        check_output("hold_vld", 32'(a2c_lkp_rsp_vld), 32'd0);
        check_output("hold_id", 32'(a2c_lkp_rsp_id), 32'h2A1);
        check_output("hold_rslt", 32'(a2c_lkp_rslt), 32'h0ABCD);
        send_and_check("miss_tag", 20'h45605, 10'h011, 20'hFFFFF);
        cfg_write(8'h05, 1'b0, 12'h123, 20'h0ABCD);
        send_and_check("miss_inval", 20'h12305, 10'h2A2, 20'hFFFFF);

        $display("[TB] backpressure");
        cfg_write(8'h05, 1'b1, 12'h123, 20'h0ABCD);
        cfg_wr_en   = 1'b1;
        cfg_wr_idx  = 8'h10;
        cfg_wr_vld  = 1'b0;
        cfg_wr_tag  = '0;
        cfg_wr_rslt = '0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 6) begin
                c2a_lkp_vld    = 1'b1;
                c2a_lkp_info   = 20'h12305;
                c2a_lkp_req_id = 10'(k + 1);
                check_output($sformatf("bp_rdy_%0d", k + 1), 32'(a2c_lkp_rdy), (k < 4) ? 32'd1 : 32'd0);
            end else begin
                c2a_lkp_vld = 1'b0;
            end
            if (a2c_lkp_rsp_vld) seen++;
            tick();
        end
        cfg_wr_en   = 1'b0;
        c2a_lkp_vld = 1'b0;
        check_output("bp_no_rsp_during_wr", 32'(seen), 32'd0);
        next_id = 1;
        pend    = 5;
        for (int c = 0; c < 20; c++) begin
            if (a2c_lkp_rsp_vld) begin
                check_output("bp_rsp_id", 32'(a2c_lkp_rsp_id), 32'(next_id));
                check_output("bp_rsp_cycle", 32'(c), 32'(next_id + 1));
                check_output("bp_rsp_rslt", 32'(a2c_lkp_rslt), 32'h0ABCD);
                next_id++;
            end
            if (pend <= 6) begin
                c2a_lkp_vld    = 1'b1;
                c2a_lkp_info   = 20'h12305;
                c2a_lkp_req_id = 10'(pend);
                if (a2c_lkp_rdy) pend++;
            end else begin
                c2a_lkp_vld = 1'b0;
            end
            tick();
        end
        c2a_lkp_vld = 1'b0;
        check_output("bp_all_rsp", 32'(next_id), 32'd7);

        $display("[TB] write priority");
        check_output("wp_rdy", 32'(a2c_lkp_rdy), 32'd1);
        c2a_lkp_vld    = 1'b1;
        c2a_lkp_info   = 20'h12305;
        c2a_lkp_req_id = 10'h055;
        tick();
        c2a_lkp_vld = 1'b0;
        cfg_wr_en   = 1'b1;
        cfg_wr_idx  = 8'h05;
        cfg_wr_vld  = 1'b1;
        cfg_wr_tag  = 12'h123;
        cfg_wr_rslt = 20'h00777;
        check_output("wp_vld_t1", 32'(a2c_lkp_rsp_vld), 32'd0);
        tick();
        cfg_wr_en = 1'b0;
        check_output("wp_vld_t2", 32'(a2c_lkp_rsp_vld), 32'd0);
        tick();
        check_output("wp_vld_t3", 32'(a2c_lkp_rsp_vld), 32'd0);
        tick();
        check_output("wp_vld_t4", 32'(a2c_lkp_rsp_vld), 32'd1);
        check_output("wp_id", 32'(a2c_lkp_rsp_id), 32'h055);
        check_output("wp_rslt", 32'(a2c_lkp_rslt), 32'h00777);
        tick();

        $display("[TB] reset mid-operation");
        cfg_wr_en   = 1'b1;
        cfg_wr_idx  = 8'h20;
        cfg_wr_vld  = 1'b0;
        cfg_wr_tag  = '0;
        cfg_wr_rslt = '0;
        for (int k = 0; k < 3; k++) begin
            c2a_lkp_vld    = 1'b1;
            c2a_lkp_info   = 20'h12305;
            c2a_lkp_req_id = 10'(32'h101 + k);
            tick();
        end
        cfg_wr_en   = 1'b0;
        c2a_lkp_vld = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_output("mrst_rdy", 32'(a2c_lkp_rdy), 32'd0);
        check_output("mrst_rsp_id", 32'(a2c_lkp_rsp_id), 32'd0);
        check_output("mrst_rslt", 32'(a2c_lkp_rslt), 32'd0);
        seen = a2c_lkp_rsp_vld ? 1 : 0;
        tick();
        check_output("mrst_rdy_after", 32'(a2c_lkp_rdy), 32'd1);
        for (int k = 0; k < 6; k++) begin
            if (a2c_lkp_rsp_vld) seen++;
            tick();
        end
        check_output("mrst_no_rsp", 32'(seen), 32'd0);
        send_and_check("mrst_miss", 20'h12305, 10'h0F0, 20'hFFFFF);

        $display("[TB] hit/miss mix");
        cfg_write(8'h05, 1'b1, 12'h123, 20'h0ABCD);
        send_and_check("mix_hit1", 20'h12305, 10'h0F1, 20'h0ABCD);
        send_and_check("mix_hit2", 20'h12305, 10'h0F2, 20'h0ABCD);
        send_and_check("mix_hit3", 20'h12305, 10'h0F3, 20'h0ABCD);
        send_and_check("mix_miss", 20'h45605, 10'h0F4, 20'hFFFFF);
`ifdef LKP_STATS_EN
        check_output("stat_hit_cnt", stat_hit_cnt, 32'd3);
        check_output("stat_miss_cnt", stat_miss_cnt, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
